alu_req_arbiter: RTL and testbench
==================================

Name: alu_req_arbiter

Overview:
- Shares one ALU datapath (control unit plus arithmetic unit, 8-bit operands) between two requesters.
- Arbitrates round-robin, latches the winner's op/operands and pulses the ALU start.
- Waits for ALU done, or aborts on timeout or divide-by-zero, then returns the 16-bit result to the owning requester over a valid/ready response channel.
- Sits between the bus-side requesters and the ALU top.

Parameters:
- W, 8: operand width; result width is 2*W.
- TIMEOUT, 64: maximum cycles spent in WAIT before aborting.
- CNT_W, 7: width of the timeout counter; must satisfy 2^CNT_W > TIMEOUT.

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  asynchronous, active-low reset (0 = reset)
- req0_valid  in  1  requester 0 has an operation
- req0_ready  out  1  requester 0 request accepted this cycle
- req0_op  in  2  00 add, 01 sub, 10 mul, 11 div
- req0_a  in  W  operand A (multiplicand / dividend)
- req0_b  in  W  operand B (multiplier / divisor)
- req1_valid, req1_ready, req1_op, req1_a, req1_b: same as requester 0, for requester 1
- rsp0_valid  out  1  response for requester 0 is held
- rsp0_ready  in  1  requester 0 consumes the response
- rsp1_valid, rsp1_ready: same as requester 0, for requester 1
- rsp_data  out  2W  result, shared by both response channels
- rsp_err  out  1  1 = divide-by-zero or timeout
- alu_start  out  1  one-cycle start pulse to the ALU
- alu_op  out  2  registered op
- alu_x  out  W  registered operand A
- alu_y  out  W  registered operand B
- alu_done  in  1  one-cycle completion pulse from the ALU
- alu_result  in  2W  ALU result; for div, {remainder, quotient}

Behaviour:
- Reset (rst=0, asynchronous):
  - state=IDLE, rr_ptr=0, counter=0.
  - All outputs 0: alu_start, alu_op, alu_x, alu_y, rsp_data, rsp_err, all ready and valid signals.
  - Reset mid-operation drops the in-flight request silently. The ALU sees no further start and any late alu_done is ignored.
- States: IDLE, ISSUE, WAIT, RESP.
- IDLE:
  - Grant is combinational. If only one valid is high, that requester wins. If both are high, requester rr_ptr wins.
  - reqN_ready = (state==IDLE) & grantN. At most one ready is high in any cycle.
  - On handshake: latch op, a, b and owner id; rr_ptr <= ~owner.
  - If op==11 and b==0: next state RESP, rsp_data=all ones, rsp_err=1; the ALU is never started.
  - Otherwise: next state ISSUE.
- ISSUE:
  - alu_start=1 for exactly this cycle; counter cleared.
  - Next state WAIT.
- WAIT:
  - Counter increments each cycle.
  - On alu_done: latch alu_result into rsp_data, rsp_err=0, next state RESP.
  - If the counter reaches TIMEOUT-1 without alu_done: rsp_data=0, rsp_err=1, next state RESP.
  - If alu_done and the timeout coincide, alu_done wins.
- RESP:
  - rspN_valid=1 for the owner only; rsp_data and rsp_err held stable.
  - When rspN_ready=1: next state IDLE.
  - No new request is accepted in the same cycle; the minimum gap between grants is therefore one IDLE cycle.
- alu_done outside WAIT: ignored.
- alu_op, alu_x and alu_y hold their latched values until the next grant.
- Latency from request acceptance to rsp_valid is ALU cycles + 2. Divide-by-zero responds 1 cycle after acceptance.
- Requester inputs are sampled only at the handshake; changes after it have no effect.
- The arbiter does not check that alu_done is a single-cycle pulse; it takes the first one seen in WAIT.

Decomposition:
- Shared package:
  - op encodings OP_ADD=2'b00, OP_SUB=2'b01, OP_MUL=2'b10, OP_DIV=2'b11
  - state encodings IDLE, ISSUE, WAIT, RESP
  - error data constant (all ones)
- One sub-module: rr_arb2, a combinational 2-way round-robin grant from valid[1:0] and ptr.
- The FSM, counter and response registers live in the top.

Test Plan:
1. Single request: req0 mul a=8'd12, b=8'd10; ALU returns alu_result=16'd120 after 9 cycles → one alu_start pulse with alu_op=10, alu_x=12, alu_y=10; rsp0_valid with rsp_data=16'd120, rsp_err=0; rsp1_valid stays 0.
2. Contention: req0 and req1 both valid from reset → req0 granted first, req1 granted next. Repeat with both held valid → grants alternate 0,1,0,1.
3. Divide by zero: req1 div a=8'd50, b=0 → alu_start never asserted; rsp1_valid one cycle after the handshake with rsp_data=16'hFFFF, rsp_err=1.
4. Timeout: req0 add, alu_done never pulses → after TIMEOUT cycles in WAIT, rsp0_valid=1 with rsp_data=0, rsp_err=1. Then inject a late alu_done → ignored, state IDLE.
5. Response backpressure: hold rsp1_ready=0 for 5 cycles → rsp1_valid and rsp_data stable throughout; req0_ready stays 0 until the response is consumed.
6. Reset mid-WAIT: pull rst low while in WAIT → all outputs 0 immediately, rr_ptr=0. A subsequent alu_done produces no response.

Source files
------------

// File: rtl/alu_req_arbiter_pkg.sv
// alu_req_arbiter_pkg: shared op/state encodings and error data for the ALU request arbiter
package alu_req_arbiter_pkg;
  typedef enum logic [1:0] {OP_ADD = 2'b00, OP_SUB = 2'b01, OP_MUL = 2'b10, OP_DIV = 2'b11} op_e;
  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_e;
  localparam logic [63:0] ERR_DATA = '1;
endpackage

// File: rtl/alu_req_arbiter_rr_arb2.sv
// rr_arb2: combinational 2-way round-robin grant (valid[1:0], ptr picks the winner on a tie -> grant[1:0] one-hot or zero)
module rr_arb2 (
  input  logic [1:0] valid,
  input  logic       ptr,
  output logic [1:0] grant
);
  assign grant[0] = valid[0] & (~valid[1] | ~ptr);
  assign grant[1] = valid[1] & (~valid[0] | ptr);
endmodule

// File: rtl/alu_req_arbiter.sv
// alu_req_arbiter: shares one ALU between two requesters (req/rsp valid-ready channels in, alu start/done out, async active-low rst)
module alu_req_arbiter
  import alu_req_arbiter_pkg::*;
#(
  parameter int W       = 8,
  parameter int TIMEOUT = 64,
  parameter int CNT_W   = 7
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           req0_valid,
  output logic           req0_ready,
  input  logic [1:0]     req0_op,
  input  logic [W-1:0]   req0_a,
  input  logic [W-1:0]   req0_b,
  input  logic           req1_valid,
  output logic           req1_ready,
  input  logic [1:0]     req1_op,
  input  logic [W-1:0]   req1_a,
  input  logic [W-1:0]   req1_b,
  output logic           rsp0_valid,
  input  logic           rsp0_ready,
  output logic           rsp1_valid,
  input  logic           rsp1_ready,
  output logic [2*W-1:0] rsp_data,
  output logic           rsp_err,
  output logic           alu_start,
  output logic [1:0]     alu_op,
  output logic [W-1:0]   alu_x,
  output logic [W-1:0]   alu_y,
  input  logic           alu_done,
  input  logic [2*W-1:0] alu_result
);
  state_e           state_q, state_d;
  logic [1:0]       grant;
  logic             owner, rr_ptr, hs, dz, tmo, rsp_ack;
  logic [CNT_W-1:0] cnt;
  logic [1:0]       sel_op;
  logic [W-1:0]     sel_a, sel_b;
  rr_arb2 u_arb (.valid({req1_valid, req0_valid}), .ptr(rr_ptr), .grant(grant));
  assign sel_op     = grant[1] ? req1_op : req0_op;
  assign sel_a      = grant[1] ? req1_a : req0_a;
  assign sel_b      = grant[1] ? req1_b : req0_b;
  // gated by rst so no ready is visible (and no handshake happens) while held in reset
  assign req0_ready = rst && state_q == IDLE && grant[0];
  assign req1_ready = rst && state_q == IDLE && grant[1];
  assign hs         = req0_ready | req1_ready;
  assign dz         = sel_op == OP_DIV && sel_b == '0;
  assign tmo        = cnt == CNT_W'(TIMEOUT - 1);
  assign rsp_ack    = owner ? rsp1_ready : rsp0_ready;
  assign alu_start  = state_q == ISSUE;
  assign rsp0_valid = state_q == RESP && !owner;
  assign rsp1_valid = state_q == RESP && owner;
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    state_d = hs ? (dz ? RESP : ISSUE) : IDLE;
      ISSUE:   state_d = WAIT;
      WAIT:    state_d = (alu_done || tmo) ? RESP : WAIT;
      default: state_d = rsp_ack ? IDLE : RESP;
    endcase
  end
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      state_q  <= IDLE;
      owner    <= 1'b0;
      rr_ptr   <= 1'b0;
      cnt      <= '0;
      alu_op   <= '0;
      alu_x    <= '0;
      alu_y    <= '0;
      rsp_data <= '0;
      rsp_err  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt     <= state_q == WAIT ? cnt + CNT_W'(1) : '0;
      if (hs) begin
        owner  <= grant[1];
        rr_ptr <= ~grant[1];
        alu_op <= sel_op;
        alu_x  <= sel_a;
        alu_y  <= sel_b;
        if (dz) begin
          rsp_data <= ERR_DATA[2*W-1:0];
          rsp_err  <= 1'b1;
        end
      end
      // done beats a coinciding timeout
      if (state_q == WAIT && alu_done) begin
        rsp_data <= alu_result;
        rsp_err  <= 1'b0;
      end else if (state_q == WAIT && tmo) begin
        rsp_data <= '0;
        rsp_err  <= 1'b1;
      end
    end
endmodule

// File: tb/tb_alu_req_arbiter.sv
// tb_alu_req_arbiter: directed + randomized transaction bench with an emulated ALU and a transaction-level model
module tb_alu_req_arbiter;
  localparam int TIMEOUT = 64;
  logic clk = 0, rst = 0;
  logic req0_valid = 0, req1_valid = 0, rsp0_ready = 0, rsp1_ready = 0, alu_done = 0;
  logic [1:0] req0_op = 0, req1_op = 0;
  logic [7:0] req0_a = 0, req0_b = 0, req1_a = 0, req1_b = 0;
  logic [15:0] alu_result = 0;
  logic req0_ready, req1_ready, rsp0_valid, rsp1_valid, rsp_err, alu_start;
  logic [15:0] rsp_data;
  logic [1:0] alu_op;
  logic [7:0] alu_x, alu_y;
  int checks = 0, failures = 0;
  bit ptr = 0;

  alu_req_arbiter #(.W(8), .TIMEOUT(TIMEOUT), .CNT_W(7)) dut (
    .clk(clk), .rst(rst),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_op(req0_op), .req0_a(req0_a), .req0_b(req0_b),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_op(req1_op), .req1_a(req1_a), .req1_b(req1_b),
    .rsp0_valid(rsp0_valid), .rsp0_ready(rsp0_ready), .rsp1_valid(rsp1_valid), .rsp1_ready(rsp1_ready),
    .rsp_data(rsp_data), .rsp_err(rsp_err), .alu_start(alu_start), .alu_op(alu_op),
    .alu_x(alu_x), .alu_y(alu_y), .alu_done(alu_done), .alu_result(alu_result));

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_ctl"}, {alu_start, alu_op, alu_x, alu_y, rsp_err, req0_ready, req1_ready, rsp0_valid, rsp1_valid}, 0);
    chk({tag, "_data"}, rsp_data, 0);
  endtask

  // One complete transaction from an IDLE cycle back to the next IDLE cycle.
  // dly = ALU cycles: done is pulsed in the dly-th WAIT cycle; accepted only if that is within TIMEOUT cycles.
  task automatic txn(input bit v0, input bit v1, input logic [1:0] o0, input logic [7:0] a0, input logic [7:0] b0,
                     input logic [1:0] o1, input logic [7:0] a1, input logic [7:0] b1, input int dly, input int bp);
    bit win;
    logic [1:0] op;
    logic [7:0] a, b;
    logic [15:0] res, expd;
    logic expe;
    req0_valid = v0; req0_op = o0; req0_a = a0; req0_b = b0;
    req1_valid = v1; req1_op = o1; req1_a = a1; req1_b = b1;
    #1;
    win = (v0 && v1) ? ptr : v1;
    chk("req0_ready", req0_ready, !win);
    chk("req1_ready", req1_ready, win);
    ptr = ~win;
    op = win ? o1 : o0; a = win ? a1 : a0; b = win ? b1 : b0;
    case (op)
      2'b00: res = 16'(a) + 16'(b);
      2'b01: res = 16'(a) - 16'(b);
      2'b10: res = 16'(a) * 16'(b);
      default: res = (b == 0) ? 16'h0 : {a % b, a / b};
    endcase
    step();
    req0_valid = 0; req1_valid = 0;
    req0_a = 8'($urandom); req0_b = 8'($urandom); req1_a = 8'($urandom); req1_op = 2'($urandom);
    if (op == 2'b11 && b == 0) begin
      expd = 16'hFFFF; expe = 1;
      chk("dz_no_start", alu_start, 0);
    end else begin
      chk("start", alu_start, 1);
      chk("alu_opxy", {alu_op, alu_x, alu_y}, {op, a, b});
      step();
      for (int j = 0; ; j++) begin
        chk("wait_quiet", {alu_start, rsp0_valid, rsp1_valid}, 0);
        if (j == dly - 1) begin alu_done = 1; alu_result = res; end
        step();
        alu_done = 0; alu_result = 16'($urandom);
        if (j == dly - 1 || j == TIMEOUT - 1) break;
      end
      expd = (dly <= TIMEOUT) ? res : 16'h0;
      expe = (dly > TIMEOUT);
    end
    chk("rsp_valid", {rsp1_valid, rsp0_valid}, win ? 2'b10 : 2'b01);
    chk("rsp_data", rsp_data, expd);
    chk("rsp_err", rsp_err, expe);
    for (int i = 0; i < bp; i++) begin
      req0_valid = 1; req1_valid = 1;
      rsp0_ready = win; rsp1_ready = !win;
      alu_done = 1'($urandom); alu_result = 16'($urandom);
      #1;
      chk("bp_no_ready", {req0_ready, req1_ready}, 0);
      chk("bp_valid", {rsp1_valid, rsp0_valid}, win ? 2'b10 : 2'b01);
      chk("bp_data", {rsp_err, rsp_data}, {expe, expd});
      step();
    end
    alu_done = 0; req0_valid = 0; req1_valid = 0;
    rsp0_ready = !win; rsp1_ready = win;
    step();
    rsp0_ready = 0; rsp1_ready = 0;
    chk("back_idle", {rsp0_valid, rsp1_valid, alu_start}, 0);
  endtask

  initial begin
    #12;
    chk_all_zero("reset");
    @(negedge clk) rst = 1;
    step();
    // contention from reset: 0 first, then alternate
    for (int k = 0; k < 4; k++) txn(1, 1, 2'b00, 8'd3 + 8'(k), 8'd4, 2'b01, 8'd20, 8'd5 + 8'(k), 2, 0);
    // single mul
    txn(1, 0, 2'b10, 8'd12, 8'd10, 2'b00, 8'd0, 8'd0, 9, 0);
    chk("mul_res_const", rsp_data, 16'd120);
    // divide by zero on requester 1
    txn(0, 1, 2'b00, 8'd0, 8'd0, 2'b11, 8'd50, 8'd0, 1, 0);
    // timeout, then a late done must be ignored
    txn(1, 0, 2'b00, 8'd7, 8'd9, 2'b00, 8'd0, 8'd0, 1000, 0);
    alu_done = 1; alu_result = 16'h1234;
    step();
    alu_done = 0;
    chk("late_done", {rsp0_valid, rsp1_valid, alu_start}, 0);
    step();
    chk("late_done2", {rsp0_valid, rsp1_valid, alu_start}, 0);
    // backpressure on requester 1
    txn(0, 1, 2'b00, 8'd0, 8'd0, 2'b11, 8'd200, 8'd7, 4, 5);
    // randomized traffic
    for (int k = 0; k < 40; k++) begin
      bit v0, v1;
      int d;
      logic [7:0] b0, b1;
      v0 = 1'($urandom); v1 = v0 ? 1'($urandom) : 1'b1;
      d = ($urandom_range(0, 9) == 0) ? 62 + int'($urandom_range(0, 4)) : int'($urandom_range(1, 12));
      b0 = ($urandom_range(0, 7) == 0) ? 8'd0 : 8'($urandom);
      b1 = ($urandom_range(0, 7) == 0) ? 8'd0 : 8'($urandom);
      txn(v0, v1, 2'($urandom), 8'($urandom), b0, 2'($urandom), 8'($urandom), b1, d, int'($urandom_range(0, 3)));
    end
    // reset in the middle of WAIT
    req1_valid = 1; req1_op = 2'b00; req1_a = 8'd1; req1_b = 8'd2;
    step();
    req1_valid = 0;
    step(); step(); step();
    chk("pre_reset_wait", {alu_start, rsp0_valid, rsp1_valid}, 0);
    rst = 0;
    #1;
    chk_all_zero("mid_reset");
    ptr = 0;
    @(negedge clk) rst = 1;
    alu_done = 1; alu_result = 16'hBEEF;
    step();
    alu_done = 0;
    chk("post_reset_done", {rsp0_valid, rsp1_valid, alu_start, rsp_err}, 0);
    chk("post_reset_data", rsp_data, 0);
    txn(1, 1, 2'b01, 8'd9, 8'd3, 2'b00, 8'd1, 8'd1, 3, 1);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
